// File: rtl/sync_gate_sequencer.sv
// Measurement-window sequencer: Sync pulse, gate delay, Gate pulse, padding to a
// programmed window length, then a one-cycle Done; repeats while ena stays high.
module sync_gate_sequencer #(
   parameter int unsigned SW = 8,
   parameter int unsigned CW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ena,
   input  logic [SW-1:0] Tsync,
   input  logic [SW-1:0] Tgdel,
   input  logic [CW-1:0] Tgate,
   input  logic [CW-1:0] Tlen,
   output logic          Sync,
   output logic          Gate,
   output logic          Done,
   output logic          Busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SYNC,
      S_GDEL,
      S_GATE,
      S_LEN,
      S_DONE
   } state_t;

   state_t        r_state;
   state_t        w_next;
   state_t        w_end_state;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] r_cnt_len;
   logic [SW-1:0] r_tsync;
   logic [SW-1:0] r_tgdel;
   logic [CW-1:0] r_tgate;
   logic [CW-1:0] r_tlen;
   logic [CW-1:0] w_cnt;
   logic [CW-1:0] w_cnt_len;
   logic [CW:0]   w_cnt_inc;
   logic [CW:0]   w_len_inc;
   logic          w_start;

   // Increments are one bit wider so the "+1" comparisons never wrap.
   assign w_cnt_inc   = {1'b0, r_cnt} + 1'b1;
   assign w_len_inc   = {1'b0, r_cnt_len} + 1'b1;
   assign w_end_state = (w_len_inc < {1'b0, r_tlen}) ? S_LEN : S_DONE;

   always_comb begin
      w_next    = r_state;
      w_cnt     = r_cnt;
      w_cnt_len = r_cnt_len;
      w_start   = 1'b0;
      unique case (r_state)
         S_IDLE, S_DONE: begin
            if (ena) begin
               w_start   = 1'b1;
               w_cnt     = '0;
               w_cnt_len = '0;
               if (Tsync != '0)      w_next = S_SYNC;
               else if (Tgdel != '0) w_next = S_GDEL;
               else if (Tgate != '0) w_next = S_GATE;
               else if (Tlen != '0)  w_next = S_LEN;
               else                  w_next = S_DONE;
            end else begin
               w_next = S_IDLE;
            end
         end
         S_SYNC, S_GDEL, S_GATE, S_LEN: begin
            if (!ena) begin
               w_next    = S_IDLE;
               w_cnt     = '0;
               w_cnt_len = '0;
            end else begin
               w_cnt_len = (&r_cnt_len) ? r_cnt_len : w_len_inc[CW-1:0];
               w_cnt     = w_cnt_inc[CW-1:0];
               case (r_state)
                  S_SYNC: if (w_cnt_inc == (CW+1)'(r_tsync)) begin
                     w_cnt = '0;
                     if (r_tgdel != '0)      w_next = S_GDEL;
                     else if (r_tgate != '0) w_next = S_GATE;
                     else                    w_next = w_end_state;
                  end
                  S_GDEL: if (w_cnt_inc == (CW+1)'(r_tgdel)) begin
                     w_cnt = '0;
                     if (r_tgate != '0) w_next = S_GATE;
                     else               w_next = w_end_state;
                  end
                  S_GATE: if (w_cnt_inc == {1'b0, r_tgate}) begin
                     w_cnt  = '0;
                     w_next = w_end_state;
                  end
                  default: begin
                     w_cnt = '0;
                     if (w_len_inc == {1'b0, r_tlen}) w_next = S_DONE;
                  end
               endcase
            end
         end
         default: begin
            w_next    = S_IDLE;
            w_cnt     = '0;
            w_cnt_len = '0;
         end
      endcase
   end

   // Outputs are registered from the next state so they track r_state exactly.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_cnt_len <= '0;
         r_tsync   <= '0;
         r_tgdel   <= '0;
         r_tgate   <= '0;
         r_tlen    <= '0;
         Sync      <= 1'b0;
         Gate      <= 1'b0;
         Done      <= 1'b0;
         Busy      <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_cnt     <= w_cnt;
         r_cnt_len <= w_cnt_len;
         if (w_start) begin
            r_tsync <= Tsync;
            r_tgdel <= Tgdel;
            r_tgate <= Tgate;
            r_tlen  <= Tlen;
         end
         Sync <= (w_next == S_SYNC);
         Gate <= (w_next == S_GATE);
         Done <= (w_next == S_DONE);
         Busy <= (w_next != S_IDLE);
      end
   end

endmodule

// File: tb/tb_sync_gate_sequencer.sv
// Bench for sync_gate_sequencer: window-offset model checked every cycle, plus
// hand-computed literal expectations at chosen cycles of each directed scenario.
module tb_sync_gate_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ena = 1'b0;
   logic [7:0]  Tsync = '0;
   logic [7:0]  Tgdel = '0;
   logic [15:0] Tgate = '0;
   logic [15:0] Tlen = '0;
   logic        Sync, Gate, Done, Busy;

   int nchk = 0;
   int nerr = 0;
   bit chk_on = 1'b0;

   sync_gate_sequencer #(.SW(8), .CW(16)) dut (
      .clk(clk), .rst(rst), .ena(ena),
      .Tsync(Tsync), .Tgdel(Tgdel), .Tgate(Tgate), .Tlen(Tlen),
      .Sync(Sync), .Gate(Gate), .Done(Done), .Busy(Busy)
   );

   always #5 clk = ~clk;

   // Model: k = offset within the current window (0 = idle, 1..W = window, W+1 = Done).
   int mk = 0, mW = 0, mTs = 0, mTd = 0, mTg = 0;

   always @(posedge clk) begin
      if (rst) begin
         mk = 0;
      end else if (mk == 0 || mk == mW + 1) begin
         if (ena) begin
            mTs = int'(Tsync);
            mTd = int'(Tgdel);
            mTg = int'(Tgate);
            mW  = (mTs + mTd + mTg > int'(Tlen)) ? mTs + mTd + mTg : int'(Tlen);
            mk  = 1;
         end else begin
            mk = 0;
         end
      end else if (!ena) begin
         mk = 0;
      end else begin
         mk = mk + 1;
      end
   end

   task automatic lit(input string nm, input logic [15:0] act, input logic [15:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         lit("model Busy", 16'(Busy), 16'(mk != 0));
         lit("model Done", 16'(Done), 16'(mk != 0 && mk == mW + 1));
         lit("model Sync", 16'(Sync), 16'(mk >= 1 && mk <= mTs && mk <= mW));
         lit("model Gate", 16'(Gate), 16'(mk > mTs + mTd && mk <= mTs + mTd + mTg && mk <= mW));
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic setT(input int s, input int d, input int g, input int l);
      Tsync = 8'(s);
      Tgdel = 8'(d);
      Tgate = 16'(g);
      Tlen  = 16'(l);
   endtask

   initial begin
      // Reset held two edges with ena=1 and all T=5
      setT(5, 5, 5, 5);
      ena = 1'b1;
      tick();
      chk_on = 1'b1;
      lit("rst busy1", 16'(Busy), 16'd0);
      tick();
      lit("rst sync2", 16'(Sync), 16'd0);
      lit("rst busy2", 16'(Busy), 16'd0);
      rst = 1'b0;
      tick();
      lit("rst start sync", 16'(Sync), 16'd1);
      ena = 1'b0;
      tick();
      lit("abort idle", 16'(Busy), 16'd0);
      tick();

      // Nominal window; Tgate changed mid-window must not matter
      setT(3, 2, 4, 20);
      ena = 1'b1;
      for (int c = 1; c <= 22; c++) begin
         tick();
         if (c == 1)  lit("nom sync c1", 16'(Sync), 16'd1);
         if (c == 3)  lit("nom sync c3", 16'(Sync), 16'd1);
         if (c == 4)  lit("nom sync c4", 16'(Sync), 16'd0);
         if (c == 5)  begin lit("nom gate c5", 16'(Gate), 16'd0); Tgate = 16'd1; end
         if (c == 6)  lit("nom gate c6", 16'(Gate), 16'd1);
         if (c == 9)  lit("nom gate c9", 16'(Gate), 16'd1);
         if (c == 10) lit("nom gate c10", 16'(Gate), 16'd0);
         if (c == 20) lit("nom done c20", 16'(Done), 16'd0);
         if (c == 21) begin lit("nom done c21", 16'(Done), 16'd1); ena = 1'b0; end
         if (c == 22) lit("nom idle c22", 16'(Busy), 16'd0);
      end

      // Short Tlen: no padding phase
      setT(2, 1, 3, 4);
      ena = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         tick();
         if (c == 3) lit("short gate c3", 16'(Gate), 16'd0);
         if (c == 4) lit("short gate c4", 16'(Gate), 16'd1);
         if (c == 6) lit("short gate c6", 16'(Gate), 16'd1);
         if (c == 7) begin lit("short done c7", 16'(Done), 16'd1); ena = 1'b0; end
         if (c == 8) lit("short idle c8", 16'(Busy), 16'd0);
      end

      // Zero-length Sync/Gdel phases
      setT(0, 0, 5, 0);
      ena = 1'b1;
      for (int c = 1; c <= 7; c++) begin
         tick();
         if (c == 1) lit("zero gate c1", 16'(Gate), 16'd1);
         if (c == 1) lit("zero sync c1", 16'(Sync), 16'd0);
         if (c == 5) lit("zero gate c5", 16'(Gate), 16'd1);
         if (c == 6) begin lit("zero done c6", 16'(Done), 16'd1); ena = 1'b0; end
         if (c == 7) lit("zero idle c7", 16'(Busy), 16'd0);
      end

      // All zero: Done in first cycle
      setT(0, 0, 0, 0);
      ena = 1'b1;
      tick();
      lit("allzero done c1", 16'(Done), 16'd1);
      ena = 1'b0;
      tick();
      lit("allzero idle c2", 16'(Busy), 16'd0);

      // Tlen only: one padding cycle then Done
      setT(0, 0, 0, 1);
      ena = 1'b1;
      tick();
      lit("lenonly done c1", 16'(Done), 16'd0);
      tick();
      lit("lenonly done c2", 16'(Done), 16'd1);
      ena = 1'b0;
      tick();

      // Back-to-back windows, abort during second Gate
      setT(1, 1, 2, 6);
      ena = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         tick();
         if (c == 6)  lit("rep done c6", 16'(Done), 16'd0);
         if (c == 7)  lit("rep done c7", 16'(Done), 16'd1);
         if (c == 8)  lit("rep sync c8", 16'(Sync), 16'd1);
         if (c == 10) begin lit("rep gate c10", 16'(Gate), 16'd1); ena = 1'b0; end
         if (c == 11) lit("rep abort c11", 16'(Busy), 16'd0);
         if (c == 12) lit("rep nodone c12", 16'(Done), 16'd0);
      end

      // Reset during LEN, then a fresh window with full timing
      setT(1, 1, 2, 30);
      ena = 1'b1;
      for (int c = 1; c <= 10; c++) tick();
      lit("midrst in len", 16'(Busy), 16'd1);
      rst = 1'b1;
      tick();
      lit("midrst busy", 16'(Busy), 16'd0);
      lit("midrst cnt_len", dut.r_cnt_len, 16'd0);
      rst = 1'b0;
      setT(2, 2, 2, 8);
      for (int c = 1; c <= 10; c++) begin
         tick();
         if (c == 2) lit("fresh sync c2", 16'(Sync), 16'd1);
         if (c == 5) lit("fresh gate c5", 16'(Gate), 16'd1);
         if (c == 7) lit("fresh gate c7", 16'(Gate), 16'd0);
         if (c == 9) begin lit("fresh done c9", 16'(Done), 16'd1); ena = 1'b0; end
         if (c == 10) lit("fresh idle c10", 16'(Busy), 16'd0);
      end

      tick();
      tick();
      chk_on = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
